// File: rtl/prime_interleaver_stream.sv
// prime_interleaver_stream: ping-pong buffered stage emitting each N-sample frame in (k*P) mod N order.
// Define PRIME_INTERLEAVER_DEINT_EN to add the per-frame `inverse` input for de-interleaving.
module prime_interleaver_stream #(
  parameter int N      = 10,
  parameter int P      = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
`ifdef PRIME_INTERLEAVER_DEINT_EN
  input  logic              inverse,
`endif
  output logic              m_last,
  output logic              frame_done
);
  localparam int AW = $clog2(N);
  function automatic int gcd(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction
  if (N < 2 || P <= 0 || P >= N || gcd(P, N) != 1) begin : g_bad_param
    $error("prime_interleaver_stream: need N>=2, 0<P<N and gcd(P,N)==1");
  end
  // modular step by P without a divider; operands stay below N
  function automatic logic [AW-1:0] step_p(input logic [AW-1:0] a);
    logic [AW:0] s;
    s = {1'b0, a} + (AW+1)'(P);
    return (s >= (AW+1)'(N)) ? AW'(s - (AW+1)'(N)) : AW'(s);
  endfunction
  logic [DATA_W-1:0] mem [2][N];
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, rd_addr_q, rd_addr_d;
  logic          frame_done_q, frame_done_d;
  logic          wr_fire, rd_fire, wr_last, rd_last;
  logic [AW-1:0] wr_a, rd_a;
`ifdef PRIME_INTERLEAVER_DEINT_EN
  logic [1:0]    inv_q, inv_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
`endif
  always_comb begin
    s_ready      = rst_n && !full_q[wr_bank_q];
    m_valid      = full_q[rd_bank_q];
    wr_fire      = s_valid && s_ready;
    rd_fire      = m_valid && m_ready;
    wr_last      = wr_idx_q == AW'(N-1);
    rd_last      = rd_idx_q == AW'(N-1);
    m_last       = m_valid && rd_last;
    full_d       = full_q;
    if (wr_fire && wr_last) full_d[wr_bank_q] = 1'b1;
    if (rd_fire && rd_last) full_d[rd_bank_q] = 1'b0;
    wr_bank_d    = wr_bank_q ^ (wr_fire && wr_last);
    rd_bank_d    = rd_bank_q ^ (rd_fire && rd_last);
    wr_idx_d     = !wr_fire ? wr_idx_q : wr_last ? '0 : wr_idx_q + 1'b1;
    rd_idx_d     = !rd_fire ? rd_idx_q : rd_last ? '0 : rd_idx_q + 1'b1;
    rd_addr_d    = !rd_fire ? rd_addr_q : rd_last ? '0 : step_p(rd_addr_q);
    frame_done_d = rd_fire && rd_last;
`ifdef PRIME_INTERLEAVER_DEINT_EN
    inv_d        = inv_q;
    if (wr_fire && wr_idx_q == '0) inv_d[wr_bank_q] = inverse;
    wr_addr_d    = !wr_fire ? wr_addr_q : wr_last ? '0 : step_p(wr_addr_q);
    // at index 0 both addresses are 0, so the stale flag of a bank is harmless
    wr_a         = inv_q[wr_bank_q] ? wr_addr_q : wr_idx_q;
    rd_a         = inv_q[rd_bank_q] ? rd_idx_q : rd_addr_q;
`else
    wr_a         = wr_idx_q;
    rd_a         = rd_addr_q;
`endif
    m_data       = mem[rd_bank_q][rd_a];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      rd_addr_q    <= '0;
      frame_done_q <= 1'b0;
`ifdef PRIME_INTERLEAVER_DEINT_EN
      inv_q        <= '0;
      wr_addr_q    <= '0;
`endif
    end else begin
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      rd_addr_q    <= rd_addr_d;
      frame_done_q <= frame_done_d;
`ifdef PRIME_INTERLEAVER_DEINT_EN
      inv_q        <= inv_d;
      wr_addr_q    <= wr_addr_d;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank_q][wr_a] <= s_data;
  end
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_prime_interleaver_stream.sv
// tb_prime_interleaver_stream: randomized bench against a frame-level permutation model.
module tb_prime_interleaver_stream;
  localparam int N = 10;
  localparam int P = 3;
  logic        clk = 0;
  logic        rst_n = 1;
  logic [31:0] s_data = 0;
  logic        s_valid = 0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 0;
  logic        m_last;
  logic        frame_done;
`ifdef PRIME_INTERLEAVER_DEINT_EN
  logic        inverse = 0;
`endif
  int          n_vec = 0, n_err = 0, rk = 0, fd_count = 0;
  bit          fd_exp = 0, stall_prev = 0, cur_inv = 0, inv_in = 0, acc = 0;
  logic [31:0] prev_data = 0;
  logic        prev_last = 0;
  logic [31:0] cur[$], expq[$], got[$], q[$];
  logic [31:0] fwd [N];

  prime_interleaver_stream #(.N(N), .P(P), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
`ifdef PRIME_INTERLEAVER_DEINT_EN
    .inverse(inverse),
`endif
    .m_last(m_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  // one clock: drive at the negedge, check against the model, then advance
  task automatic step(input bit sv, input logic [31:0] sd, input bit mr);
    bit ev, er, rd, wr;
    logic [31:0] f [N];
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
`ifdef PRIME_INTERLEAVER_DEINT_EN
    inverse = inv_in;
`endif
    #1;
    ev = expq.size() != 0;
    er = (expq.size() + N - 1) / N < 2;
    chk("m_valid", m_valid, ev);
    chk("s_ready", s_ready, er);
    chk("frame_done", frame_done, fd_exp);
    chk("m_last", m_last, ev && rk == N-1);
    if (stall_prev) begin
      chk("hold_data", m_data, prev_data);
      chk("hold_last", m_last, prev_last);
    end
    if (frame_done) fd_count++;
    rd = ev && mr;
    wr = sv && er;
    acc = wr;
    fd_exp = rd && rk == N-1;
    if (rd) begin
      chk("m_data", m_data, expq.pop_front());
      got.push_back(m_data);
      rk = (rk == N-1) ? 0 : rk + 1;
    end
    if (wr) begin
      if (cur.size() == 0) cur_inv = inv_in;
      cur.push_back(sd);
      if (cur.size() == N) begin
        for (int k = 0; k < N; k++)
          if (cur_inv) f[(k*P)%N] = cur[k];
          else f[k] = cur[(k*P)%N];
        for (int k = 0; k < N; k++) expq.push_back(f[k]);
        cur.delete();
      end
    end
    stall_prev = ev && !mr;
    prev_data  = m_data;
    prev_last  = m_last;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    s_valid = 0;
    m_ready = 0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_frame_done", frame_done, 0);
    cur.delete();
    expq.delete();
    rk = 0;
    fd_exp = 0;
    stall_prev = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drain(input int maxc, input bit rnd);
    int c = 0;
    while (expq.size() != 0 && c < maxc) begin
      step(0, 0, rnd ? 1'($urandom) : 1'b1);
      c++;
    end
    step(0, 0, 1);
    chk("drain_timeout", expq.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, c;
    fwd = '{1, 4, 7, 10, 3, 6, 9, 2, 5, 8};
    #2;
    do_reset();
    got.delete();
    for (int i = 1; i <= N; i++) step(1, i, 1);
    drain(50, 0);
    chk("fwd_count", got.size(), N);
    for (int i = 0; i < N; i++) chk("fwd_order", got[i], fwd[i]);
    fd_count = 0;
    for (int i = 0; i < 3*N; i++) step(1, $urandom, 1);
    drain(50, 0);
    chk("b2b_frame_done", fd_count, 3);
    for (int i = 0; i < 2*N; i++) step(1, $urandom, 0);
    step(1, 32'hdead_beef, 0);
    step(0, 0, 0);
    drain(100, 0);
    idx = 0;
    c = 0;
    while (idx < 5*N && c < 2000) begin
      step(1'($urandom), $urandom, 1'($urandom));
      if (acc) idx++;
      c++;
    end
    chk("rand_sent", idx, 5*N);
    drain(1000, 1);
    for (int i = 1; i <= 4; i++) step(1, 32'h100 + i, 1);
    do_reset();
    got.delete();
    for (int i = 1; i <= N; i++) step(1, i, 1);
    drain(50, 0);
    chk("rst_mid_count", got.size(), N);
    for (int i = 0; i < N; i++) chk("rst_mid_order", got[i], fwd[i]);
`ifdef PRIME_INTERLEAVER_DEINT_EN
    got.delete();
    inv_in = 0;
    for (int i = 1; i <= N; i++) step(1, i, 1);
    drain(50, 0);
    q = got;
    got.delete();
    inv_in = 1;
    for (int i = 0; i < N; i++) step(1, q[i], 1);
    drain(50, 0);
    inv_in = 0;
    chk("deint_count", got.size(), N);
    for (int i = 0; i < N; i++) chk("deint_order", got[i], i + 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/prime_interleaver_stream.md
Name: prime_interleaver_stream

Overview:
- Streaming hardware stage that feeds the max-product turbo decoder's second constituent decoder.
- Accepts frames of N samples in natural order on a valid/ready input and emits each frame in prime-interleaved order.
- Output index k reads input index (k*P) mod N, which is the same permutation as the interleaver_prime_if Forward() model.
- Ping-pong double buffer: one frame is written while the previous frame is read, so continuous streams run with no bubbles.

Parameters:
- N, 10, frame length in samples (N >= 2).
- P, 3, interleaver step. gcd(P,N)=1 and 0 < P < N, checked by an elaboration-time assertion.
- DATA_W, 32, sample width in bits. Real LLRs are carried as shortreal bit patterns.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  DATA_W  input sample, natural order.
- s_valid  in  1  input sample valid.
- s_ready  out  1  stage can accept s_data.
- m_data  out  DATA_W  interleaved output sample.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts m_data.
- m_last  out  1  marks the final sample of an output frame; qualified by m_valid.
- frame_done  out  1  one-cycle pulse when the last sample of a frame is accepted downstream.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Asserting rst_n=0 immediately clears the following:
  - full[1:0]=0, wr_bank=0, rd_bank=0, wr_idx=0, rd_idx=0, rd_addr=0.
  - s_ready=0 while in reset, then 1 from the first cycle after release.
  - m_valid=0, m_last=0, frame_done=0.
  - Memory contents are not reset.
- Storage: mem[2][N] of DATA_W registers. Counters are $clog2(N) bits wide.
- Write side:
  - s_ready = !full[wr_bank].
  - On s_valid && s_ready: mem[wr_bank][wr_idx] <= s_data, then wr_idx increments.
  - When wr_idx==N-1 is accepted: wr_idx<=0, full[wr_bank]<=1, wr_bank toggles.
- Read side:
  - m_valid = full[rd_bank].
  - m_data = mem[rd_bank][rd_addr], a combinational read from registers.
  - m_last = m_valid && (rd_idx==N-1).
- Read address: on m_valid && m_ready, rd_idx increments and rd_addr <= (rd_addr+P >= N) ? rd_addr+P-N : rd_addr+P. No multiplier or divider is used.
- Last output sample: on acceptance with rd_idx==N-1:
  - rd_idx<=0, rd_addr<=0.
  - full[rd_bank]<=0, rd_bank toggles.
  - frame_done pulses high for 1 cycle, registered, so it is visible on the cycle after acceptance.
- Latency: first m_valid rises the cycle after the N-th input sample is accepted.
- Throughput: 1 sample/clk in steady state when m_ready=1.
- Simultaneous events:
  - A write completing bank A and a read releasing bank B in the same cycle are both applied.
  - If the write toggles onto the bank being released in that cycle, s_ready is 1 on the next cycle. No bubble.
- Boundaries:
  - Both banks full: s_ready=0 until the read side releases a bank.
  - Both banks empty: m_valid=0.
  - wr_bank==rd_bank implies that bank is either empty (write side owns it) or full (read side owns it), never both.
- m_data and m_last hold stable while m_valid && !m_ready.
- Reset mid-frame: all partial write and read progress is discarded. No output is produced for the interrupted frame.

Optional Feature:
- Macro PRIME_INTERLEAVER_DEINT_EN.
- When defined:
  - Adds input port `inverse` (1 bit).
  - The value of `inverse` is latched per bank when that bank's first sample (wr_idx==0) is accepted.
  - For an inverse bank, the write address follows the (i*P) mod N stepping and the read address is natural order (rd_addr=rd_idx). This performs de-interleaving, giving the exact inverse permutation.
  - The latched flag is cleared by reset.
- When undefined:
  - No port is added.
  - The block is forward-only, with no extra registers.

Test Plan:
- Forward frame: N=10, P=3, input 1..10, m_ready=1 -> output 1,4,7,10,3,6,9,2,5,8. m_last on the 8. First m_valid arrives 1 cycle after 10 is accepted.
- Back-to-back: 3 frames streamed continuously, s_valid=1 and m_ready=1 -> s_ready stays 1 after the first frame, m_valid is continuous for 30 cycles, and frame_done pulses 3 times spaced 10 cycles apart.
- Backpressure: m_ready=0 while 20 samples are written -> s_ready=0 after the 20th sample. Then m_ready=1 -> both frames emerge correctly permuted and s_ready returns to 1.
- Random valid/ready toggling over 5 frames of random 32-bit data -> output equals the (k*3) mod 10 permutation per frame, and m_data stays stable during stalls.
- Reset mid-frame: assert rst_n=0 after 4 of 10 samples, then send a fresh 1..10 -> output is exactly one frame, 1,4,7,...,8, with no residue from the interrupted frame.
- With PRIME_INTERLEAVER_DEINT_EN: send 1..10 with inverse=0, feed the output back in with inverse=1 -> the recovered sequence is 1..10.
